cpu_control_fsm: RTL and testbench

Moore control state machine for the SIMPLE RISC CPU: sequences instruction fetch, PC update, decode, datapath register transfers and data-memory access for every Lab 7 instruction (MOV, ALU ops, LDR, STR, HALT). Sits inside `CPU`, between the instruction register / memory interface and the datapath `DP`. It produces every load, select and memory-command strobe that drives `PC`, `REGFILE` and `MEM`.

---
 rtl/cpu_control_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//
// Moore control sequencer for the SIMPLE RISC CPU. It fetches an instruction
// over two read cycles, bumps the PC, decodes {opcode,op}, and then walks the
// datapath through the register transfers and memory accesses the
// instruction needs. Every output is a registered decode of the state, so
// the strobes come straight from flops and carry no input-to-output path.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; forces RST with no clock
//   opcode     IR[15:13], sampled only in DECODE
//   op         IR[12:11], sampled only in DECODE
//   nsel       one-hot register select (100 Rn, 010 Rd, 001 Rm, 000 none)
//   vsel       writeback source (00 C, 01 PC, 10 sximm8, 11 mdata)
//   write      register-file write enable
//   loada/b/c  datapath A/B/C register enables
//   loads      status register enable
//   asel       1 forces ALU A input to zero
//   bsel       1 selects sximm5 as ALU B input
//   load_ir    instruction register enable
//   load_pc    PC enable
//   reset_pc   PC next value is 0 (else PC+1)
//   addr_sel   1: memory address from PC, 0: from data-address register
//   load_addr  data-address register enable
//   mem_cmd    00 none, 01 read, 10 write
//   halted     high while in HALT
// ---------------------------------------------------------------------------
module cpu_control_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  localparam logic [2:0] NSEL_NONE  = 3'b000;
  localparam logic [2:0] NSEL_RN    = 3'b100;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b001;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;
  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_READ   = 2'b01;
  localparam logic [1:0] CMD_WRITE  = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE,
    S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG,
    S_ADDR, S_LOAD_ADDR, S_MEM_RD, S_WRITE_MDATA,
    S_GET_RD, S_STR_C, S_MEM_WR, S_HALT
  } state_t;

  // Instruction class latched in DECODE. The shared states (GET_A, ALU,
  // LOAD_ADDR) use it to pick their outputs and successor, so the FSM never
  // looks at opcode/op outside DECODE.
  typedef enum logic [2:0] {
    I_SHIFT,  // MOV Rd,Rm{,sh} and MVN: ALU sees only B
    I_ARITH,  // ADD and AND: result written to Rd
    I_CMP,    // CMP: status only
    I_LDR,
    I_STR
  } instr_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } ctrl_t;

  state_t state, state_nxt;
  instr_t instr, instr_nxt;
  ctrl_t  ctrl;

  // Output decode for one state; anything not set stays inactive.
  function automatic ctrl_t ctrl_of(input state_t s, input instr_t i);
    ctrl_t c;
    c         = '0;
    c.nsel    = NSEL_NONE;
    c.vsel    = VSEL_C;
    c.mem_cmd = CMD_NONE;
    case (s)
      S_RST:         begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:         begin c.addr_sel = 1'b1; c.mem_cmd = CMD_READ; end
      S_IF2:         begin c.addr_sel = 1'b1; c.mem_cmd = CMD_READ; c.load_ir = 1'b1; end
      S_UPDATE_PC:   c.load_pc = 1'b1;
      S_WRITE_IMM:   begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
      S_GET_A:       begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B:       begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_ALU: begin
        if (i == I_CMP) begin
          c.loads = 1'b1;
        end else begin
          c.loadc = 1'b1;
          c.asel  = (i == I_SHIFT);
        end
      end
      S_WRITE_REG:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      S_ADDR:        begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LOAD_ADDR:   c.load_addr = 1'b1;
      S_MEM_RD:      c.mem_cmd = CMD_READ;
      S_WRITE_MDATA: begin
        c.mem_cmd = CMD_READ;
        c.nsel    = NSEL_RD;
        c.vsel    = VSEL_MDATA;
        c.write   = 1'b1;
      end
      S_GET_RD:      begin c.nsel = NSEL_RD; c.loadb = 1'b1; end
      S_STR_C:       begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MEM_WR:      c.mem_cmd = CMD_WRITE;
      S_HALT:        c.halted = 1'b1;
      default:       ;
    endcase
    return c;
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the case statements can leave one unassigned (a latch).
  always_comb begin
    state_nxt = state;
    instr_nxt = instr;
    case (state)
      S_RST:       state_nxt = S_IF1;
      S_IF1:       state_nxt = S_IF2;
      S_IF2:       state_nxt = S_UPDATE_PC;
      S_UPDATE_PC: state_nxt = S_DECODE;
      S_DECODE: begin
        state_nxt = S_IF1;  // undefined encodings fall through as a NOP
        casez ({opcode, op})
          5'b110_10:                     state_nxt = S_WRITE_IMM;
          5'b110_00, 5'b101_11:          begin state_nxt = S_GET_B; instr_nxt = I_SHIFT; end
          5'b101_00, 5'b101_10:          begin state_nxt = S_GET_A; instr_nxt = I_ARITH; end
          5'b101_01:                     begin state_nxt = S_GET_A; instr_nxt = I_CMP;   end
          5'b011_00:                     begin state_nxt = S_GET_A; instr_nxt = I_LDR;   end
          5'b100_00:                     begin state_nxt = S_GET_A; instr_nxt = I_STR;   end
          5'b111_??:                     state_nxt = S_HALT;
          default:                       ;
        endcase
      end
      S_WRITE_IMM:   state_nxt = S_IF1;
      S_GET_A:       state_nxt = (instr == I_LDR || instr == I_STR) ? S_ADDR : S_GET_B;
      S_GET_B:       state_nxt = S_ALU;
      S_ALU:         state_nxt = (instr == I_CMP) ? S_IF1 : S_WRITE_REG;
      S_WRITE_REG:   state_nxt = S_IF1;
      S_ADDR:        state_nxt = S_LOAD_ADDR;
      S_LOAD_ADDR:   state_nxt = (instr == I_LDR) ? S_MEM_RD : S_GET_RD;
      S_MEM_RD:      state_nxt = S_WRITE_MDATA;
      S_WRITE_MDATA: state_nxt = S_IF1;
      S_GET_RD:      state_nxt = S_STR_C;
      S_STR_C:       state_nxt = S_MEM_WR;
      S_MEM_WR:      state_nxt = S_IF1;
      S_HALT:        state_nxt = S_HALT;
      default:       state_nxt = S_RST;
    endcase
  end

  // The output register is loaded with the decode of the state being
  // entered, so outputs and state always change on the same edge and the
  // async reset puts the RST strobes on the pins without a clock.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      instr <= I_SHIFT;
      ctrl  <= ctrl_of(S_RST, I_SHIFT);
    end else begin
      state <= state_nxt;
      instr <= instr_nxt;
      ctrl  <= ctrl_of(state_nxt, instr_nxt);
    end
  end

  assign nsel      = ctrl.nsel;
  assign vsel      = ctrl.vsel;
  assign write     = ctrl.write;
  assign loada     = ctrl.loada;
  assign loadb     = ctrl.loadb;
  assign loadc     = ctrl.loadc;
  assign loads     = ctrl.loads;
  assign asel      = ctrl.asel;
  assign bsel      = ctrl.bsel;
  assign load_ir   = ctrl.load_ir;
  assign load_pc   = ctrl.load_pc;
  assign reset_pc  = ctrl.reset_pc;
  assign addr_sel  = ctrl.addr_sel;
  assign load_addr = ctrl.load_addr;
  assign mem_cmd   = ctrl.mem_cmd;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
//
// Wraps the control FSM in a small behavioural CPU (memory, IR, PC, register
// file, A/B/C, status, data-address register) driven purely by the FSM's
// strobes. An instruction-level interpreter holds the expected architectural
// state and the expected per-instruction signature (cycle count, write and
// memory-write pulses, loads/loada/asel counts, write select). Both are
// compared after every instruction.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       write, loada, loadb, loadc, loads, asel, bsel;
  logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, halted;
  logic [1:0] mem_cmd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .op(op),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
    .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
    .halted(halted)
  );

  // Output vectors for the two states the bench recognises directly.
  localparam logic [19:0] RST_OUTS = 20'b000_00_00000000_1100_00_0;
  localparam logic [19:0] IF1_OUTS = 20'b000_00_00000000_0010_01_0;

  function automatic logic [19:0] outs();
    return {nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
            load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, halted};
  endfunction

  function automatic logic in_if1();
    return addr_sel && (mem_cmd == 2'b01) && !load_ir;
  endfunction

  function automatic logic [15:0] shift_val(input logic [15:0] v, input logic [1:0] s);
    case (s)
      2'd0:    return v;
      2'd1:    return {v[14:0], 1'b0};
      2'd2:    return {1'b0, v[15:1]};
      default: return {v[15], v[15:1]};
    endcase
  endfunction

  // ------------------------------------------------------------ environment
  logic [15:0] mem [0:511];
  logic [15:0] rf  [0:7];
  logic [15:0] ir, ra, rb, rc, mdata;
  logic [8:0]  pc, daddr;
  logic        z_flag, n_flag;
  logic [2:0]  rsel;
  logic [15:0] bsh, ain, bin, alu, wdata;
  logic [8:0]  maddr;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];

  always_comb begin
    rsel = 3'd0;
    case (nsel)
      3'b100:  rsel = ir[10:8];
      3'b010:  rsel = ir[7:5];
      3'b001:  rsel = ir[2:0];
      default: rsel = 3'd0;
    endcase
    bsh = (ir[15:13] == 3'b101 || ir[15:13] == 3'b110) ? shift_val(rb, ir[4:3]) : rb;
    ain = asel ? 16'd0 : ra;
    bin = bsel ? {{11{ir[4]}}, ir[4:0]} : bsh;
    case (ir[12:11])
      2'd0:    alu = ain + bin;
      2'd1:    alu = ain - bin;
      2'd2:    alu = ain & bin;
      default: alu = ~bin;
    endcase
    case (vsel)
      2'd0:    wdata = rc;
      2'd1:    wdata = {7'b0, pc};
      2'd2:    wdata = {{8{ir[7]}}, ir[7:0]};
      default: wdata = mdata;
    endcase
    maddr = addr_sel ? pc : daddr;
  end

  always @(posedge clk) begin
    if (mem_cmd == 2'b01) mdata <= mem[maddr];
    if (mem_cmd == 2'b10) mem[maddr] <= rc;
    if (load_ir)   ir <= mdata;
    if (write)     rf[rsel] <= wdata;
    if (loada)     ra <= rf[rsel];
    if (loadb)     rb <= rf[rsel];
    if (loadc)     rc <= alu;
    if (loads)     begin z_flag <= (alu == 16'd0); n_flag <= alu[15]; end
    if (load_addr) daddr <= rc[8:0];
    if (load_pc)   pc <= reset_pc ? 9'd0 : pc + 9'd1;
  end

  // ------------------------------------------------------- reference model
  logic [15:0] m_mem [0:511];
  logic [15:0] m_rf  [0:7];
  logic [8:0]  m_pc;
  logic        m_z, m_n;

  typedef struct packed {
    logic [7:0] cycles;
    logic [3:0] writes;
    logic [3:0] mem_writes;
    logic [3:0] loads_n;
    logic [3:0] loada_n;
    logic [3:0] asel_n;
    logic [2:0] wr_nsel;
    logic [1:0] wr_vsel;
    logic       halted;
    logic       timeout;
  } obs_t;

  function automatic string fmt(input obs_t o);
    return $sformatf("cyc=%0d wr=%0d memwr=%0d lds=%0d lda=%0d asel=%0d nsel=%b vsel=%b halt=%b timeout=%b",
                     o.cycles, o.writes, o.mem_writes, o.loads_n, o.loada_n, o.asel_n,
                     o.wr_nsel, o.wr_vsel, o.halted, o.timeout);
  endfunction

  // Executes one instruction architecturally and returns the strobe
  // signature the control unit must produce for it.
  task automatic model_step(output obs_t e);
    logic [15:0] w, b, res, sum;
    logic [2:0]  rn, rd, rm;
    logic [8:0]  a;
    w    = m_mem[m_pc];
    m_pc = m_pc + 9'd1;
    e    = '0;
    rn   = w[10:8];
    rd   = w[7:5];
    rm   = w[2:0];
    b    = shift_val(m_rf[rm], w[4:3]);
    sum  = m_rf[rn] + {{11{w[4]}}, w[4:0]};
    a    = sum[8:0];
    casez ({w[15:13], w[12:11]})
      5'b110_10: begin
        m_rf[rn] = {{8{w[7]}}, w[7:0]};
        e.cycles = 8'd5; e.writes = 4'd1; e.wr_nsel = 3'b100; e.wr_vsel = 2'b10;
      end
      5'b110_00, 5'b101_11: begin
        m_rf[rd] = (w[12:11] == 2'b11) ? ~b : b;
        e.cycles = 8'd7; e.writes = 4'd1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b00;
        e.asel_n = 4'd1;
      end
      5'b101_00, 5'b101_10: begin
        m_rf[rd] = (w[12:11] == 2'b00) ? m_rf[rn] + b : m_rf[rn] & b;
        e.cycles = 8'd8; e.writes = 4'd1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b00;
        e.loada_n = 4'd1;
      end
      5'b101_01: begin
        res = m_rf[rn] - b;
        m_z = (res == 16'd0);
        m_n = res[15];
        e.cycles = 8'd7; e.loads_n = 4'd1; e.loada_n = 4'd1;
      end
      5'b011_00: begin
        m_rf[rd] = m_mem[a];
        e.cycles = 8'd9; e.writes = 4'd1; e.wr_nsel = 3'b010; e.wr_vsel = 2'b11;
        e.loada_n = 4'd1;
      end
      5'b100_00: begin
        m_mem[a] = m_rf[rd];
        e.cycles = 8'd10; e.mem_writes = 4'd1; e.loada_n = 4'd1; e.asel_n = 4'd1;
      end
      5'b111_??: begin
        e.cycles = 8'd4; e.halted = 1'b1;
      end
      default: e.cycles = 8'd4;
    endcase
  endtask

  function automatic logic state_matches();
    logic ok = 1'b1;
    if (pc !== m_pc || z_flag !== m_z || n_flag !== m_n) ok = 1'b0;
    for (int i = 0; i < 8; i++)   if (rf[i]  !== m_rf[i])  ok = 1'b0;
    for (int i = 0; i < 512; i++) if (mem[i] !== m_mem[i]) ok = 1'b0;
    return ok;
  endfunction

  // Runs the DUT from an IF1 sample to the next IF1 (or HALT), collecting
  // the observed signature, and steps the model by one instruction.
  task automatic exec_instr(output obs_t got, output obs_t exp, output logic state_ok);
    got = '0;
    model_step(exp);
    do begin
      if (write) begin
        got.writes  = got.writes + 4'd1;
        got.wr_nsel = nsel;
        got.wr_vsel = vsel;
      end
      if (mem_cmd == 2'b10) got.mem_writes = got.mem_writes + 4'd1;
      if (loads) got.loads_n = got.loads_n + 4'd1;
      if (loada) got.loada_n = got.loada_n + 4'd1;
      if (asel)  got.asel_n  = got.asel_n + 4'd1;
      got.cycles = got.cycles + 8'd1;
      @(negedge clk);
    end while (!in_if1() && !halted && got.cycles < 8'd40);
    got.timeout = (got.cycles >= 8'd40);
    got.halted  = halted;
    state_ok    = state_matches();
  endtask

  // Loads a program into both memories under reset and leaves the DUT at
  // its first IF1 sample.
  task automatic start_program(input logic [15:0] p[$]);
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 512; i++) begin mem[i] = 16'd0; m_mem[i] = 16'd0; end
    for (int i = 0; i < 8; i++)   begin rf[i] = 16'd0;  m_rf[i] = 16'd0;  end
    for (int i = 0; i < p.size(); i++) begin mem[i] = p[i]; m_mem[i] = p[i]; end
    z_flag = 1'b0; n_flag = 1'b0; m_z = 1'b0; m_n = 1'b0; m_pc = 9'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] enc_movi(input logic [2:0] rn, input logic [7:0] imm);
    return {3'b110, 2'b10, rn, imm};
  endfunction
  function automatic logic [15:0] enc_alu(input logic [2:0] opc, input logic [1:0] o,
                                          input logic [2:0] rn, input logic [2:0] rd,
                                          input logic [1:0] sh, input logic [2:0] rm);
    return {opc, o, rn, rd, sh, rm};
  endfunction
  function automatic logic [15:0] enc_mem(input logic [2:0] opc, input logic [2:0] rn,
                                          input logic [2:0] rd, input logic [4:0] imm5);
    return {opc, 2'b00, rn, rd, imm5};
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++; $display("FAIL reset_async: observed outputs %b required %b", outs(), RST_OUTS);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++; $display("FAIL reset_hold: observed outputs %b required %b", outs(), RST_OUTS);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== IF1_OUTS || pc !== 9'd0) begin
      errors++; $display("FAIL reset_release: observed outputs %b pc %h required %b pc 000", outs(), pc, IF1_OUTS);
    end
  endtask

  task automatic test_mov_imm();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    p = '{16'hD005, 16'hE000};
    start_program(p);
    exec_instr(got, exp, ok);
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mov_imm_ctrl: observed %s expected %s", fmt(got), fmt(exp)); end
    checks++;
    if (!ok || rf[0] !== 16'd5 || pc !== 9'd1) begin
      errors++; $display("FAIL mov_imm_state: observed r0=%h pc=%0d required r0=0005 pc=1", rf[0], pc);
    end
  endtask

  task automatic test_fig6();
    obs_t got, exp; logic ok, bad;
    logic [15:0] p[$];
    p = '{16'hD005, 16'h6020, 16'hD206, 16'h8220, 16'hE000, 16'hABCD};
    start_program(p);
    for (int k = 0; k < 5; k++) begin
      exec_instr(got, exp, ok);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fig6_ctrl[%0d]: observed %s expected %s", k, fmt(got), fmt(exp)); end
      checks++;
      if (!ok) begin errors++; $display("FAIL fig6_state[%0d]: observed pc=%0d expected pc=%0d (or reg/mem/flag difference)", k, pc, m_pc); end
      if (k == 1) begin
        checks++;
        if (rf[1] !== 16'hABCD) begin errors++; $display("FAIL fig6_ldr: observed r1=%h required abcd", rf[1]); end
      end
    end
    checks++;
    if (mem[6] !== 16'hABCD || pc !== 9'd5) begin
      errors++; $display("FAIL fig6_str: observed mem[6]=%h pc=%0d required abcd pc=5", mem[6], pc);
    end
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (!halted || pc !== 9'd5 || write || mem_cmd !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL fig6_halt: observed halted=%b pc=%0d required halted=1 pc=5 idle", halted, pc); end
  endtask

  task automatic test_alu();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    p = '{enc_movi(3'd0, 8'd7), enc_movi(3'd1, 8'hFE),
          enc_alu(3'b101, 2'b00, 3'd1, 3'd2, 2'd0, 3'd0),   // ADD R2,R1,R0
          enc_alu(3'b101, 2'b01, 3'd1, 3'd0, 2'd0, 3'd0),   // CMP R1,R0
          enc_alu(3'b101, 2'b01, 3'd0, 3'd0, 2'd0, 3'd0),   // CMP R0,R0
          enc_alu(3'b101, 2'b10, 3'd1, 3'd3, 2'd1, 3'd0),   // AND R3,R1,R0,LSL#1
          16'hE000};
    start_program(p);
    for (int k = 0; k < 7; k++) begin
      exec_instr(got, exp, ok);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_ctrl[%0d]: observed %s expected %s", k, fmt(got), fmt(exp)); end
      checks++;
      if (!ok) begin errors++; $display("FAIL alu_state[%0d]: observed pc=%0d expected pc=%0d (or reg/mem/flag difference)", k, pc, m_pc); end
    end
    checks++;
    if (rf[2] !== 16'd5 || z_flag !== 1'b1) begin
      errors++; $display("FAIL alu_result: observed r2=%h z=%b required r2=0005 z=1", rf[2], z_flag);
    end
  endtask

  task automatic test_shift();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    p = '{enc_movi(3'd1, 8'h85),
          enc_alu(3'b101, 2'b11, 3'd0, 3'd3, 2'd0, 3'd1),   // MVN R3,R1
          enc_alu(3'b110, 2'b00, 3'd0, 3'd4, 2'd3, 3'd1),   // MOV R4,R1,ASR#1
          enc_alu(3'b110, 2'b00, 3'd0, 3'd5, 2'd2, 3'd1),   // MOV R5,R1,LSR#1
          16'hE000};
    start_program(p);
    for (int k = 0; k < 5; k++) begin
      exec_instr(got, exp, ok);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL shift_ctrl[%0d]: observed %s expected %s", k, fmt(got), fmt(exp)); end
      checks++;
      if (!ok) begin errors++; $display("FAIL shift_state[%0d]: observed pc=%0d expected pc=%0d (or reg/mem/flag difference)", k, pc, m_pc); end
    end
    checks++;
    if (rf[3] !== 16'h007A || rf[4] !== 16'hFFC2 || rf[5] !== 16'h7FC2) begin
      errors++; $display("FAIL shift_result: observed r3=%h r4=%h r5=%h required 007a ffc2 7fc2", rf[3], rf[4], rf[5]);
    end
  endtask

  task automatic test_nop();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    p = '{16'h0000, 16'h7800, 16'hE000};
    start_program(p);
    for (int k = 0; k < 3; k++) begin
      exec_instr(got, exp, ok);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL nop_ctrl[%0d]: observed %s expected %s", k, fmt(got), fmt(exp)); end
      checks++;
      if (!ok) begin errors++; $display("FAIL nop_state[%0d]: observed pc=%0d expected pc=%0d (or reg/mem/flag difference)", k, pc, m_pc); end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] r6, ra7, rb7;
    logic [1:0] sh;
    r6  = 3'($urandom_range(0, 6));   // R7 holds the data base, never a destination
    ra7 = 3'($urandom_range(0, 7));
    rb7 = 3'($urandom_range(0, 7));
    sh  = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 8))
      0:       return enc_movi(r6, 8'($urandom));
      1:       return enc_alu(3'b110, 2'b00, ra7, r6, sh, rb7);
      2:       return enc_alu(3'b101, 2'b11, ra7, r6, sh, rb7);
      3:       return enc_alu(3'b101, 2'b00, ra7, r6, sh, rb7);
      4:       return enc_alu(3'b101, 2'b10, ra7, r6, sh, rb7);
      5:       return enc_alu(3'b101, 2'b01, ra7, r6, sh, rb7);
      6:       return enc_mem(3'b011, 3'd7, r6, 5'($urandom));
      7:       return enc_mem(3'b100, 3'd7, ra7, 5'($urandom));
      default: return {3'($urandom_range(0, 2)), 13'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    for (int t = 0; t < 3; t++) begin
      p = {};
      p.push_back(enc_movi(3'd7, 8'h80));   // data window around 0x180
      for (int i = 0; i < 30; i++) p.push_back(rand_instr());
      p.push_back(16'hE000);
      start_program(p);
      for (int k = 0; k < 32; k++) begin
        exec_instr(got, exp, ok);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rand%0d_ctrl[%0d] (%h): observed %s expected %s", t, k, ir, fmt(got), fmt(exp)); end
        checks++;
        if (!ok) begin errors++; $display("FAIL rand%0d_state[%0d]: observed pc=%0d expected pc=%0d (or reg/mem/flag difference)", t, k, pc, m_pc); end
        if (exp.halted || got.timeout) break;
      end
    end
  endtask

  task automatic test_reset_mid_str();
    obs_t got, exp; logic ok;
    logic [15:0] p[$];
    p = '{enc_movi(3'd1, 8'hFD), enc_movi(3'd2, 8'd6), enc_mem(3'b100, 3'd2, 3'd1, 5'd0), 16'hE000};
    start_program(p);
    mem[6] = 16'h1234; m_mem[6] = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      exec_instr(got, exp, ok);
      checks++;
      if (got !== exp) begin errors++; $display("FAIL midstr_ctrl[%0d]: observed %s expected %s", k, fmt(got), fmt(exp)); end
    end
    for (int i = 0; i < 20 && mem_cmd !== 2'b10; i++) @(negedge clk);
    checks++;
    if (mem_cmd !== 2'b10) begin
      errors++; $display("FAIL midstr_reach_memwr: observed mem_cmd=%b within 20 cycles required 10", mem_cmd);
    end else begin
      reset_n = 1'b0;
      #1;
      checks++;
      if (outs() !== RST_OUTS) begin
        errors++; $display("FAIL midstr_abort: observed outputs %b required %b", outs(), RST_OUTS);
      end
      @(posedge clk);
      #1;
      checks++;
      if (mem[6] !== 16'h1234) begin
        errors++; $display("FAIL midstr_no_write: observed mem[6]=%h required 1234", mem[6]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== IF1_OUTS || pc !== 9'd0) begin
        errors++; $display("FAIL midstr_restart: observed outputs %b pc %0d required %b pc 0", outs(), pc, IF1_OUTS);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_mov_imm();
    test_fig6();
    test_alu();
    test_shift();
    test_nop();
    test_random();
    test_reset_mid_str();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
